// File: rtl/colour_sequencer.sv
// colour_sequencer: steps a writable RGB palette with forward, ping-pong, crossfade and hold modes
module colour_sequencer #(
    parameter int CHANNEL_WIDTH = 4,
    parameter int NUM_STEPS = 8,
    parameter int DWELL_WIDTH = 32,
    parameter int IDX_WIDTH = $clog2(NUM_STEPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [DWELL_WIDTH-1:0]     dwell,
    input  logic                       wr_en,
    input  logic [IDX_WIDTH-1:0]       wr_addr,
    input  logic [3*CHANNEL_WIDTH-1:0] wr_data,
    output logic [CHANNEL_WIDTH-1:0]   red,
    output logic [CHANNEL_WIDTH-1:0]   green,
    output logic [CHANNEL_WIDTH-1:0]   blue,
    output logic [IDX_WIDTH-1:0]       index,
    output logic                       wrap
);
    localparam int CW = CHANNEL_WIDTH;
    localparam int PW = 3 * CW;
    localparam logic [1:0] MODE_FWD = 2'd0, MODE_PING = 2'd1, MODE_FADE = 2'd2;
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_STEPS - 1);

    function automatic logic [PW-1:0] dflt(int i);
        int p;
        p = i % 8;
        return {{CW{p >= 4}}, {CW{p inside {2, 3, 4, 7}}}, {CW{p inside {1, 2, 6, 7}}}};
    endfunction

    function automatic logic [PW-1:0] fade_step(logic [PW-1:0] cur, logic [PW-1:0] tgt);
        logic [PW-1:0] r;
        r = cur;
        for (int c = 0; c < 3; c++)
            r[c*CW +: CW] = cur[c*CW +: CW] < tgt[c*CW +: CW] ? cur[c*CW +: CW] + 1'b1 :
                            cur[c*CW +: CW] > tgt[c*CW +: CW] ? cur[c*CW +: CW] - 1'b1 : cur[c*CW +: CW];
        return r;
    endfunction

    logic [PW-1:0] pal [NUM_STEPS];
    logic [PW-1:0] fade, fade_nxt, target, shown;
    logic [DWELL_WIDTH-1:0] count;
    logic [IDX_WIDTH-1:0] idx_inc, idx_ping, idx_nxt;
    logic dir_down, dir_nxt, tick, matched;

    always_comb begin
        tick = en && count >= dwell;
        idx_inc = index == LAST ? '0 : index + 1'b1;
        idx_ping = dir_down ? (index == '0 ? IDX_WIDTH'(1) : index - 1'b1)
                            : (index == LAST ? LAST - 1'b1 : index + 1'b1);
        dir_nxt = dir_down ? index != '0 : index == LAST;
        target = pal[idx_inc];
        matched = fade == target;
        idx_nxt = !tick ? index :
                  mode == MODE_FWD ? idx_inc :
                  mode == MODE_PING ? idx_ping :
                  mode == MODE_FADE && matched ? idx_inc : index;
        // outside crossfade the fade register shadows the palette so entering mode 2 is seamless
        fade_nxt = mode != MODE_FADE ? pal[index] : (tick && !matched) ? fade_step(fade, target) : fade;
        shown = mode == MODE_FADE ? fade : pal[index];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            index <= '0;
            dir_down <= 1'b0;
            fade <= '0;
            wrap <= 1'b0;
            {blue, green, red} <= '0;
            for (int i = 0; i < NUM_STEPS; i++) pal[i] <= dflt(i);
        end else begin
            if (en) begin
                count <= tick ? '0 : count + 1'b1;
                index <= idx_nxt;
                dir_down <= (tick && mode == MODE_PING) ? dir_nxt : dir_down;
                fade <= fade_nxt;
            end
            wrap <= idx_nxt == '0 && index != '0;
            {blue, green, red} <= shown;
            if (wr_en && {1'b0, wr_addr} < (IDX_WIDTH + 1)'(NUM_STEPS)) pal[wr_addr] <= wr_data;
        end
    end
endmodule
